sregn_rr_arbiter: RTL and testbench
===================================

Name: sregn_rr_arbiter

Overview:
- Shares one enable-gated output register (width bits, cleared on reset) among n requesters.
- Grant order is round-robin.
- The register is a single-entry buffer with a valid/ready output handshake and a same-cycle drain-and-reload path, so it can sustain one transfer per cycle.
- Sits between several producer stages and one consumer stage in generated datapaths.

Parameters:
- width, 32, data width of each requester and of the shared register.
- n, 4, number of requesters; legal range 2..16.
- srcw, 2, width of the source-index output; must satisfy n <= 2**srcw.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- enable  in  1  global stall; 0 freezes all state and forces gnt to 0.
- req  in  n  per-requester request; requester holds req and its data stable until granted.
- i0  in  n*width  requester data, flattened; requester k occupies bits [k*width +: width].
- gnt  out  n  combinational one-hot grant; a grant bit is high only in the cycle its data is captured.
- o_valid  out  1  shared register holds unconsumed data.
- o_ready  in  1  consumer accepts when o_valid and o_ready are both 1 on a clock edge.
- o0  out  width  shared register contents.
- o_src  out  srcw  index of the requester whose data is in o0.

Behaviour:
- Reset (synchronous, overrides everything):
  - o_valid=0, o0=0, o_src=0.
  - Priority pointer ptr=0, so requester 0 has highest priority.
  - gnt=0 during any cycle in which reset=1.
- Derived signals:
  - drain = o_valid & o_ready.
  - space = ~o_valid | o_ready (empty, or being drained this cycle).
  - load = enable & space & (|req).
- Arbitration (combinational):
  - Search req cyclically starting at index ptr: ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  - The first asserted req wins (index w).
  - gnt[w]=load; all other gnt bits are 0.
  - gnt is never multi-hot, and is 0 whenever load=0.
- Register update on posedge clk, reset=0, enable=1:
  - If load: o0 <= i0[w], o_src <= w, o_valid <= 1, ptr <= (w+1) mod n. Wrap: w=n-1 gives ptr=0.
  - Else if drain: o_valid <= 0. o0 and o_src hold their last values and are don't-care for the consumer.
  - Else: hold.
  - A simultaneous drain and load is a back-to-back transfer: o_valid stays 1 and the new data appears the next cycle.
- Stall, enable=0:
  - No capture and no ptr change; o_valid, o0, o_src hold.
  - gnt=0 even if o_ready=1.
  - A consumer handshake during a stall is not honoured; o_valid stays 1 and the data is re-presented.
- State machine, two states (EMPTY: o_valid=0; FULL: o_valid=1):
  - EMPTY -> FULL on load.
  - FULL -> FULL on load with drain, or on no drain.
  - FULL -> EMPTY on drain without load.
- Latency: a request in an EMPTY cycle is granted that cycle, and o0/o_valid are visible after the next posedge (1 cycle).
- Throughput: 1 transfer per cycle while o_ready=1 and any req is pending.
- Fairness: a continuously asserted req is granted within n loads.
- ptr changes only on load, never on drain alone.
- Requests deasserted before grant are simply skipped; no state is kept per requester.
- Reset asserted mid-transfer discards the held data; a requester's pending req must re-arbitrate after reset.

Test Plan:
- Reset, then req=4'b0001, i0[0]=32'hA5A5_0001, o_ready=0 -> gnt=0001 that cycle; next cycle o_valid=1, o0=A5A5_0001, o_src=0; gnt=0 while FULL and o_ready=0.
- req=4'b1111 held, o_ready=1, enable=1, from reset -> grants 0,1,2,3,0,... one per cycle; o_src sequence 0,1,2,3,0; o_valid stays 1 throughout (back-to-back).
- ptr=3 (after granting 2), req=4'b0101 -> gnt=0001 (wrap past 3 to 0); next grant with same req gives gnt=0100.
- FULL, o_ready=1, req=0 -> o_valid drops to 0 next cycle; o0 unchanged; ptr unchanged.
- FULL, o_ready=1, req=4'b0010, enable=0 for 3 cycles -> gnt=0, o_valid=1, o0 held; enable=1 -> gnt=0010 same cycle, drain and load together.
- FULL with o_src=2, assert reset for 1 cycle with req=4'b1000 -> next cycle o_valid=0, o0=0, o_src=0, gnt=0 during reset; following cycle gnt=1000.

Source files
------------

// File: rtl/sregn_rr_arbiter.sv
// Round-robin arbiter feeding one shared valid/ready output register.
// Sustains one transfer per cycle via a same-cycle drain-and-reload path.
//
//   state | meaning
//   ------+---------------------------------------------
//   EMPTY | o0 holds no unconsumed data (o_valid = 0)
//   FULL  | o0 holds data awaiting the consumer (o_valid = 1)
module sregn_rr_arbiter #(
  parameter int width = 32,
  parameter int n     = 4,
  parameter int srcw  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [n-1:0]       req,
  input  logic [n*width-1:0] i0,
  output logic [n-1:0]       gnt,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [width-1:0]   o0,
  output logic [srcw-1:0]    o_src
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_nxt;
  logic [srcw-1:0]   ptr;
  logic [srcw-1:0]   win;
  logic [srcw-1:0]   ptr_nxt;
  logic [srcw:0]     cand;
  logic              found;
  logic              drain;
  logic              space;
  logic              load;

  assign o_valid = (state == FULL);

  // Cyclic search from ptr; cand carries one extra bit so the wrap compare is exact.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < n; i++) begin
      cand = {1'b0, ptr} + (srcw+1)'(i);
      if (cand >= (srcw+1)'(n)) cand = cand - (srcw+1)'(n);
      if (!found && req[cand[srcw-1:0]]) begin
        found = 1'b1;
        win   = cand[srcw-1:0];
      end
    end
  end

  always_comb begin
    drain     = enable & o_valid & o_ready;
    space     = ~o_valid | o_ready;
    load      = ~reset & enable & space & found;
    gnt       = '0;
    if (load) gnt[win] = 1'b1;
    ptr_nxt   = (win == srcw'(n-1)) ? '0 : win + 1'b1;
    state_nxt = state;
    case (state)
      EMPTY: if (load) state_nxt = FULL;
      FULL:  if (drain && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      ptr   <= '0;
      o0    <= '0;
      o_src <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        o0    <= i0[win*width +: width];
        o_src <= win;
        ptr   <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sregn_rr_arbiter.sv
// Scoreboard bench for sregn_rr_arbiter: a reference model predicts grants,
// captured words are queued at grant time and compared while presented.
module tb_sregn_rr_arbiter;

  localparam int W = 32;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           enable;
  logic [N-1:0]   req;
  logic [N*W-1:0] i0;
  logic [N-1:0]   gnt;
  logic           o_valid;
  logic           o_ready;
  logic [W-1:0]   o0;
  logic [S-1:0]   o_src;

  sregn_rr_arbiter #(.width(W), .n(N), .srcw(S)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .i0(i0),
    .gnt(gnt), .o_valid(o_valid), .o_ready(o_ready), .o0(o0), .o_src(o_src)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [35:0] sb_q[$];
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic        m_zero = 1'b0;
  int          seq = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive, check at negedge, advance the model at posedge.
  task automatic cyc(input logic r, input logic e, input logic [N-1:0] rq, input logic rd);
    int          w;
    logic        ld;
    logic        dr;
    logic [N-1:0] eg;
    logic [35:0] top;
    reset = r; enable = e; req = rq; o_ready = rd;
    for (int k = 0; k < N; k++)
      i0[k*W +: W] = {16'hA5A5, 8'(seq), 8'(k+1)};
    @(negedge clk);
    w = -1;
    for (int i = 0; i < N; i++) begin
      int c = (m_ptr + i) % N;
      if (w < 0 && rq[c]) w = c;
    end
    ld = !r && e && (!m_valid || rd) && (w >= 0);
    dr = !r && e && m_valid && rd;
    eg = '0;
    if (ld) eg[w] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("o_valid", 32'(o_valid), 32'(m_valid));
    if (m_zero) begin
      chk("o0_rst", o0, 32'h0);
      chk("o_src_rst", 32'(o_src), 32'h0);
    end
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'(sb_q.size()), 32'h1);
      end else begin
        top = sb_q[0];
        chk("o0", o0, top[31:0]);
        chk("o_src", 32'(o_src), 32'(top[35:32]));
        if (dr) void'(sb_q.pop_front());
      end
    end
    if (ld) sb_q.push_back({4'(w), i0[w*W +: W]});
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_ptr = 0; m_zero = 1'b1; sb_q.delete();
    end else if (ld) begin
      m_valid = 1'b1; m_ptr = (w + 1) % N; m_zero = 1'b0;
    end else if (dr) begin
      m_valid = 1'b0;
    end
    seq++;
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; req = '0; o_ready = 1'b0; i0 = '0;
    @(posedge clk); #1;
    // reset holds gnt low even with a pending request
    cyc(1, 1, 4'b0001, 0);
    seq = 0;
    cyc(0, 1, 4'b0001, 0);
    cyc(0, 1, 4'b0010, 0);
    cyc(0, 1, 4'b0010, 0);
    // back-to-back round robin from reset
    cyc(1, 1, 4'b0000, 0);
    repeat (6) cyc(0, 1, 4'b1111, 1);
    cyc(0, 1, 4'b0100, 1);
    cyc(0, 1, 4'b0101, 1);
    cyc(0, 1, 4'b0101, 1);
    // drain only: valid drops, ptr unchanged
    cyc(0, 1, 4'b0000, 1);
    cyc(0, 1, 4'b0000, 0);
    // stall while FULL with a ready consumer
    cyc(0, 1, 4'b1000, 0);
    repeat (3) cyc(0, 0, 4'b0010, 1);
    cyc(0, 1, 4'b0010, 1);
    cyc(0, 1, 4'b0000, 0);
    // reset mid-transfer with o_src=2
    cyc(0, 1, 4'b0100, 1);
    cyc(0, 1, 4'b0100, 0);
    cyc(1, 1, 4'b1000, 0);
    cyc(0, 1, 4'b1000, 0);
    cyc(0, 1, 4'b0000, 1);
    // random traffic
    for (int t = 0; t < 400; t++)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0),
          N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
